mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port backing memory between the instruction-fetch port (IF)
//  and the data port of the memory stage (D). Holds a request/ack handshake on each port
//  and sequences one backing-memory transaction at a time through a 4-state FSM.
//  D has priority; a starvation guard bounds the IF wait. A watchdog aborts backend stalls.
// PARAMETERS
//  ADDR_W       32  address width, all ports
//  DATA_W       32  data width, all ports
//  TIMEOUT_CYC  16  max cycles mem_req may stay high without mem_ack (>=1)
//  STARVE_LIM   4   consecutive D grants with IF pending before IF is forced (>=1)
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       IF read request; held with if_addr until if_ack
//  if_addr    in   ADDR_W  IF read address
//  if_rdata   out  DATA_W  IF read data, valid with if_ack
//  if_ack     out  1       IF completion, 1-cycle pulse
//  d_req      in   1       D request; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1       1=write, 0=read
//  d_addr     in   ADDR_W  D address
//  d_wdata    in   DATA_W  D write data
//  d_rdata    out  DATA_W  D read data, valid with d_ack (0 on write)
//  d_ack      out  1       D completion, 1-cycle pulse
//  err        out  1       qualifies the ack pulse of the same cycle: 1 = timed out
//  mem_req    out  1       backend request, held until mem_ack or timeout
//  mem_we     out  1       backend write enable
//  mem_addr   out  ADDR_W  backend address
//  mem_wdata  out  DATA_W  backend write data
//  mem_rdata  in   DATA_W  backend read data, valid with mem_ack
//  mem_ack    in   1       backend completion, 1-cycle pulse
// BEHAVIOUR
//  - Reset: state IDLE, counters 0. All outputs 0: acks, err, rdata, mem_req, mem_we,
//    mem_addr, mem_wdata. All outputs are registered.
//  - States: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE.
//  - IDLE:
//    - Samples if_req/d_req. Only d_req: GRANT_D. Only if_req: GRANT_I. Neither: stay.
//    - Both: GRANT_D, except GRANT_I when starve_cnt==STARVE_LIM.
//    - On a grant, the winner's payload is captured into mem_addr/mem_we/mem_wdata
//      and mem_req is set on the next cycle.
//    - IF grants always drive mem_we=0 and mem_wdata=0.
//  - starve_cnt:
//    - Increments on a D grant while if_req=1, saturating at STARVE_LIM.
//    - Clears on any IF grant.
//  - GRANT_x:
//    - mem_req=1, payload stable. wd_cnt increments each cycle that mem_ack=0.
//    - mem_ack=1: latch mem_rdata (D write: latch 0), mem_req->0, go to RESP with err=0.
//    - wd_cnt reaches TIMEOUT_CYC-1 with mem_ack still 0: mem_req->0, rdata=0,
//      go to RESP with err=1.
//    - wd_cnt clears on entry to GRANT_x.
//  - RESP:
//    - Exactly one cycle: x_ack=1 and x_rdata valid; err as decided.
//    - Requests are not sampled in RESP. The requester drops req the cycle after ack.
//    - Then IDLE.
//  - Hold behaviour: rdata outputs hold their last value between acks. acks and err are 0
//    outside RESP.
//  - Latency:
//    - Minimum is req seen in IDLE (cycle 0) -> mem_req (1) -> mem_ack (1) -> ack (2).
//    - The next grant is possible at cycle 3.
//  - mem_ack outside GRANT_x (late ack after timeout, spurious ack) is ignored.
//  - mem_rdata is don't-care when mem_ack=0.
//  - Reset mid-transaction: the transaction is abandoned. The next cycle has mem_req=0
//    and no ack is ever issued for it.
//  - Request withdrawn before ack is a protocol violation, not handled.
// TESTING
//  1. IF read: if_req at addr 0x10, mem_ack 2 cycles after mem_req with
//     mem_rdata=0x00500093 -> if_ack pulses once, if_rdata=0x00500093, err=0, mem_we=0.
//  2. Simultaneous: if_req and d_req raised in the same cycle (d_addr=0x40, if_addr=0x4)
//     -> first mem_addr=0x40, d_ack, then mem_addr=0x4, if_ack. No overlap of mem_req.
//  3. Starvation: d_req re-raised immediately after each d_ack, if_req held
//     -> 4 D grants, 5th grant is IF, starve_cnt clears, following grant is D.
//  4. Timeout: D read with mem_ack tied 0 -> mem_req high exactly 16 cycles, then
//     d_ack=1/err=1/d_rdata=0. A mem_ack pulse 3 cycles later is ignored.
//  5. Write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_we=1,
//     mem_wdata=0xDEADBEEF until mem_ack, then d_ack with d_rdata=0.
//  6. Reset mid-grant: rst for 1 cycle while mem_req=1 -> next cycle all outputs 0, no ack.
//     A fresh if_req then completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port backing memory.
// D wins ties unless IF has been starved too long; a watchdog ends stalled backend requests.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned STARVE_LIM  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGrantI = 2'd1;
    localparam logic [1:0] StGrantD = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam int unsigned WdW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned StW = $clog2(STARVE_LIM + 1);
    localparam logic [WdW-1:0] WdLast    = WdW'(TIMEOUT_CYC - 1);
    localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIM);

    logic [1:0]        state_q, state_d;
    logic [WdW-1:0]    wd_cnt_q, wd_cnt_d;
    logic [StW-1:0]    starve_cnt_q, starve_cnt_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              done;
    logic [DATA_W-1:0] done_data;
    logic              if_forced;

    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = wd_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done         = 1'b0;
        done_data    = '0;
        if_forced    = if_req && (starve_cnt_q == StarveMax);

        case (state_q)
            StIdle: begin
                if (d_req && !if_forced) begin
                    state_d     = StGrantD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    wd_cnt_d    = '0;
                    // Below the limit here whenever IF is pending, so no overflow.
                    if (if_req) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d      = StGrantI;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
                    wd_cnt_d     = '0;
                    starve_cnt_d = '0;
                end
            end
            StGrantI, StGrantD: begin
                done      = mem_ack || (wd_cnt_q == WdLast);
                done_data = (mem_ack && !mem_we_q) ? mem_rdata : '0;
                if (!done) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end else begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack;
                    if (state_q == StGrantD) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = done_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = done_data;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wd_cnt_q     <= '0;
            starve_cnt_q <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO),
        .STARVE_LIM (SL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicted output values for the current cycle.
    logic          m_if_ack = 0, m_d_ack = 0, m_err = 0, m_mem_req = 0, m_mem_we = 0;
    logic [DW-1:0] m_if_rdata = 0, m_d_rdata = 0, m_mem_wdata = 0;
    logic [AW-1:0] m_mem_addr = 0;
    bit            m_busy = 0, m_for_d = 0, m_ack_cycle = 0;
    int            m_req_cycles = 0;
    int            m_starve = 0;

    task automatic model_complete(input bit timed_out, input logic [DW-1:0] data);
        m_mem_req   = 0;
        m_busy      = 0;
        m_ack_cycle = 1;
        m_err       = timed_out;
        if (m_for_d) begin
            m_d_ack   = 1;
            m_d_rdata = data;
        end else begin
            m_if_ack   = 1;
            m_if_rdata = data;
        end
    endtask

    task automatic model_grant(input bit to_d, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd);
        m_busy       = 1;
        m_for_d      = to_d;
        m_req_cycles = 1;
        m_mem_req    = 1;
        m_mem_we     = we;
        m_mem_addr   = a;
        m_mem_wdata  = wd;
    endtask

    // Compare, then advance the model using the inputs the next rising edge will sample.
    always @(negedge clk) begin
        check("if_ack", if_ack, m_if_ack);
        check("d_ack", d_ack, m_d_ack);
        check("err", err, m_err);
        check("if_rdata", if_rdata, m_if_rdata);
        check("d_rdata", d_rdata, m_d_rdata);
        check("mem_req", mem_req, m_mem_req);
        if (m_mem_req) begin
            check("mem_we", mem_we, m_mem_we);
            check("mem_addr", mem_addr, m_mem_addr);
            check("mem_wdata", mem_wdata, m_mem_wdata);
        end
        m_if_ack = 0;
        m_d_ack  = 0;
        m_err    = 0;
        if (rst) begin
            m_mem_req = 0; m_mem_we = 0; m_mem_addr = 0; m_mem_wdata = 0;
            m_if_rdata = 0; m_d_rdata = 0;
            m_busy = 0; m_ack_cycle = 0; m_starve = 0;
        end else if (m_ack_cycle) begin
            m_ack_cycle = 0;
        end else if (m_busy) begin
            if (mem_ack) model_complete(0, m_mem_we ? '0 : mem_rdata);
            else if (m_req_cycles == TO) model_complete(1, '0);
            else m_req_cycles++;
        end else if (d_req && !(if_req && m_starve == SL)) begin
            model_grant(1, d_we, d_addr, d_wdata);
            if (if_req) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
        end else if (if_req) begin
            model_grant(0, 1'b0, if_addr, '0);
            m_starve = 0;
        end
    end

    // Backend responder: ack ack_delay cycles into each request (or a random delay).
    int            ack_delay = 1;
    bit            rand_mode = 0;
    bit            spur_now  = 0;
    logic [DW-1:0] resp_data = '0;
    int            rsp_age   = 0;
    int            rsp_dly   = 0;

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r == 6) return TO - 1;
        if (r == 7) return TO;
        if (r == 8) return TO + 4;
        return 1;
    endfunction

    always @(posedge clk) begin
        #2;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (rsp_age == 0) rsp_dly = rand_mode ? pick_delay() : ack_delay;
            mem_rdata = $urandom;
            if (rsp_age == rsp_dly) begin
                mem_ack = 1'b1;
                if (!rand_mode) mem_rdata = resp_data;
            end
            rsp_age++;
        end else begin
            rsp_age = 0;
            if (spur_now || (rand_mode && $urandom_range(0, 9) == 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next ack, recording latency, mem_req-high cycles and the first payload.
    task automatic wait_ack(output int cyc, output int req_cyc, output logic [AW-1:0] f_addr,
                            output logic f_we, output logic [DW-1:0] f_wdata);
        bit seen = 0;
        cyc = 0; req_cyc = 0; f_addr = '0; f_we = 1'b0; f_wdata = '0;
        do begin
            tick();
            cyc++;
            if (mem_req) begin
                req_cyc++;
                if (!seen) begin
                    seen = 1; f_addr = mem_addr; f_we = mem_we; f_wdata = mem_wdata;
                end
            end
        end while (!(if_ack || d_ack) && cyc < 100);
        check("ack_within_bound", if_ack | d_ack, 1'b1);
    endtask

    int            cyc, rcyc;
    logic [AW-1:0] fa;
    logic          fw;
    logic [DW-1:0] fd;
    logic [AW-1:0] starve_exp [6];

    initial begin
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) tick();
        rst = 0;
        check("rst_mem_req", mem_req, 0);
        check("rst_acks", {if_ack, d_ack, err}, 0);
        check("rst_payload", {mem_we, mem_addr, mem_wdata}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        tick();

        // IF read, backend acks two cycles after mem_req rises
        if_addr = 32'h10; if_req = 1; ack_delay = 2; resp_data = 32'h0050_0093;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t1_if_ack", if_ack, 1);
        check("t1_if_rdata", if_rdata, 32'h0050_0093);
        check("t1_err", err, 0);
        check("t1_mem_we", fw, 0);
        check("t1_mem_addr", fa, 32'h10);
        check("t1_latency", cyc, 4);
        if_req = 0;
        tick();
        check("t1_single_pulse", if_ack, 0);

        // Simultaneous requests: D first
        d_addr = 32'h40; d_we = 0; if_addr = 32'h4; ack_delay = 0;
        d_req = 1; if_req = 1;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t2_first_is_d", {d_ack, if_ack}, 2'b10);
        check("t2_first_addr", fa, 32'h40);
        check("t2_min_latency", cyc, 2);
        d_req = 0;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t2_second_is_if", {d_ack, if_ack}, 2'b01);
        check("t2_second_addr", fa, 32'h4);
        if_req = 0;
        tick();

        // Starvation guard: four D grants, then IF, then D again
        starve_exp = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h8, 32'h104};
        if_addr = 32'h8; if_req = 1; d_addr = 32'h100; d_req = 1; ack_delay = 0;
        for (int g = 0; g < 6; g++) begin
            wait_ack(cyc, rcyc, fa, fw, fd);
            check($sformatf("t3_grant%0d", g), fa, starve_exp[g]);
            if (d_ack) d_addr = d_addr + 1;
            if (if_ack) if_req = 0;
        end
        d_req = 0;
        tick();

        // Watchdog timeout, then a late backend ack that must be ignored
        ack_delay = 1000; d_we = 0; d_addr = 32'h44; d_req = 1;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t4_d_ack", d_ack, 1);
        check("t4_err", err, 1);
        check("t4_rdata_zero", d_rdata, 0);
        check("t4_req_cycles", rcyc, 16);
        d_req = 0;
        tick(); tick(); tick();
        spur_now = 1;
        tick();
        spur_now = 0;
        for (int k = 0; k < 4; k++) begin
            check("t4_late_ack_ignored", {if_ack, d_ack, err, mem_req}, 0);
            tick();
        end

        // Write
        d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; ack_delay = 3;
        resp_data = 32'h1234_5678; d_req = 1;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t5_mem_we", fw, 1);
        check("t5_mem_wdata", fd, 32'hDEAD_BEEF);
        check("t5_mem_addr", fa, 32'h20);
        check("t5_d_ack", d_ack, 1);
        check("t5_d_rdata", d_rdata, 0);
        check("t5_err", err, 0);
        d_req = 0; d_we = 0;
        tick();

        // Reset in the middle of a grant
        ack_delay = 1000; if_addr = 32'h30; if_req = 1;
        tick(); tick();
        check("t6_req_before_rst", mem_req, 1);
        rst = 1; if_req = 0;
        tick();
        rst = 0;
        check("t6_after_rst", {mem_req, mem_we, mem_addr, mem_wdata, if_ack, d_ack, err}, 0);
        check("t6_rdata_cleared", {if_rdata, d_rdata}, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t6_no_ack", {if_ack, d_ack}, 0);
        end
        ack_delay = 1; resp_data = 32'hCAFE_F00D; if_addr = 32'h34; if_req = 1;
        wait_ack(cyc, rcyc, fa, fw, fd);
        check("t6_fresh_if_ack", if_ack, 1);
        check("t6_fresh_rdata", if_rdata, 32'hCAFE_F00D);
        check("t6_fresh_err", err, 0);
        if_req = 0;
        tick();

        // Randomized traffic; the model checks every cycle
        rand_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst) rst = 0;
            if (if_ack) if_req = 0;
            if (d_ack) d_req = 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if ($urandom_range(0, 399) == 0) begin
                rst = 1; if_req = 0; d_req = 0;
            end
        end
        rst = 0; rand_mode = 0; if_req = 0; d_req = 0;
        repeat (25) tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
